// File: rtl/io_bridge_if.sv
// Host-link and core-pin bundle for io_bridge.
// master = host/core side driving the bridge, slave = the bridge itself.
interface io_bridge_if;
  logic [15:0] HostInData;
  logic        HostInValid;
  logic        HostInReady;
  logic [15:0] HostOutData;
  logic        HostOutValid;
  logic        HostOutReady;
  logic        HostFlash;
  logic        HostLast;
  logic        IOWaiting;
  logic        IOWrite;
  logic [15:0] ParallelOut;
  logic        IOReady;
  logic [15:0] ParallelIn;
  logic        FlashEnable;
  logic        CoreHold;

  modport master (
    output HostInData, HostInValid, HostOutReady, HostFlash, HostLast,
           IOWaiting, IOWrite, ParallelOut,
    input  HostInReady, HostOutData, HostOutValid, IOReady, ParallelIn,
           FlashEnable, CoreHold
  );

  modport slave (
    input  HostInData, HostInValid, HostOutReady, HostFlash, HostLast,
           IOWaiting, IOWrite, ParallelOut,
    output HostInReady, HostOutData, HostOutValid, IOReady, ParallelIn,
           FlashEnable, CoreHold
  );
endinterface

// File: rtl/io_bridge.sv
// Off-chip responder for the confusedcore parallel I/O port: host<->core word FIFOs plus IROM loader.
// Define IO_BRIDGE_LOOPBACK_EN to add the Loopback port (core writes return through the input FIFO).
module io_bridge #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
`ifdef IO_BRIDGE_LOOPBACK_EN
  input  logic       Loopback,
`endif
  io_bridge_if.slave bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_FLASH = 2'd1, S_DONE = 2'd2} state_e;

  state_e       state_q, state_d;
  logic [IAW:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OAW:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [15:0]  in_mem_q  [IN_DEPTH];
  logic [15:0]  out_mem_q [OUT_DEPTH];
  logic         in_ready_q, in_ready_d;
  logic         io_ready_q, io_ready_d;
  logic         flash_en_q, flash_en_d;
  logic         hold_q, hold_d;
  logic [15:0]  pin_q, pin_d;

  logic         lb, host_acc, in_push, in_pop, out_push, out_pop, flush;
  logic         in_empty, in_full, out_empty, out_full, in_full_nx;
  logic         io_req;
  logic [15:0]  in_wdata;

`ifdef IO_BRIDGE_LOOPBACK_EN
  assign lb = Loopback & (state_q == S_RUN);
`else
  assign lb = 1'b0;
`endif

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) && (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) && (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
  assign out_pop   = ~out_empty & bus.HostOutReady;
  assign host_acc  = bus.HostInValid & bus.HostInReady;
  // The cycle carrying an IOReady pulse still shows the old IOWaiting, so it is ignored then.
  assign io_req    = bus.IOWaiting & ~io_ready_q;

  assign bus.HostInReady  = in_ready_q & ~lb;
  assign bus.HostOutValid = ~out_empty;
  assign bus.HostOutData  = out_mem_q[out_rd_q[OAW-1:0]];
  assign bus.IOReady      = io_ready_q;
  assign bus.ParallelIn   = pin_q;
  assign bus.FlashEnable  = flash_en_q;
  assign bus.CoreHold     = hold_q;

  // Next-state, FIFO pointer and registered-output computation
  always_comb begin
    state_d    = state_q;
    io_ready_d = 1'b0;
    flash_en_d = 1'b0;
    pin_d      = pin_q;
    in_push    = 1'b0;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    flush      = 1'b0;
    in_wdata   = bus.HostInData;
    case (state_q)
      S_RUN: begin
        if (bus.HostFlash && !io_ready_q) begin
          state_d = S_FLASH;
          flush   = 1'b1;
        end else begin
          in_push = host_acc;
          if (io_req && !bus.IOWrite && !in_empty) begin
            in_pop     = 1'b1;
            pin_d      = in_mem_q[in_rd_q[IAW-1:0]];
            io_ready_d = 1'b1;
          end else if (io_req && bus.IOWrite && lb && !in_full) begin
            in_push    = 1'b1;
            in_wdata   = bus.ParallelOut;
            io_ready_d = 1'b1;
          end else if (io_req && bus.IOWrite && !lb && (!out_full || out_pop)) begin
            out_push   = 1'b1;
            io_ready_d = 1'b1;
          end else begin
            io_ready_d = 1'b0;
          end
        end
      end
      S_FLASH: begin
        if (host_acc) begin
          flash_en_d = 1'b1;
          pin_d      = bus.HostInData;
          state_d    = bus.HostLast ? S_DONE : S_FLASH;
        end else begin
          flash_en_d = 1'b0;
        end
      end
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    out_wr_d = out_wr_q + (OAW+1)'(out_push);
    out_rd_d = out_rd_q + (OAW+1)'(out_pop);
    if (flush) begin
      in_wr_d = {(IAW+1){1'b0}};
      in_rd_d = {(IAW+1){1'b0}};
    end else begin
      in_wr_d = in_wr_q + (IAW+1)'(in_push);
      in_rd_d = in_rd_q + (IAW+1)'(in_pop);
    end
    in_full_nx = (in_wr_d[IAW] != in_rd_d[IAW]) && (in_wr_d[IAW-1:0] == in_rd_d[IAW-1:0]);

    case (state_d)
      S_FLASH: in_ready_d = 1'b1;
      S_RUN:   in_ready_d = ~in_full_nx;
      default: in_ready_d = 1'b0;
    endcase
    hold_d = (state_d != S_RUN);
  end

  // State, pointers, FIFO storage and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_RUN;
      in_wr_q    <= {(IAW+1){1'b0}};
      in_rd_q    <= {(IAW+1){1'b0}};
      out_wr_q   <= {(OAW+1){1'b0}};
      out_rd_q   <= {(OAW+1){1'b0}};
      in_ready_q <= 1'b0;
      io_ready_q <= 1'b0;
      flash_en_q <= 1'b0;
      hold_q     <= 1'b0;
      pin_q      <= 16'h0000;
      for (int i = 0; i < IN_DEPTH; i++) in_mem_q[i] <= 16'h0000;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= 16'h0000;
    end else begin
      state_q    <= state_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      in_ready_q <= in_ready_d;
      io_ready_q <= io_ready_d;
      flash_en_q <= flash_en_d;
      hold_q     <= hold_d;
      pin_q      <= pin_d;
      if (in_push) in_mem_q[in_wr_q[IAW-1:0]] <= in_wdata;
      if (out_push) out_mem_q[out_wr_q[OAW-1:0]] <= bus.ParallelOut;
    end
  end
endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: queue-based behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_io_bridge;
  localparam int D = 4;

  logic clk;
  logic rst;
`ifdef IO_BRIDGE_LOOPBACK_EN
  logic loopback;
`endif
  io_bridge_if bus();

  io_bridge #(.IN_DEPTH(D), .OUT_DEPTH(D)) dut (
    .clk   (clk),
    .reset (rst),
`ifdef IO_BRIDGE_LOOPBACK_EN
    .Loopback (loopback),
`endif
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // behavioural model
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  int          mode = 0;   // 0 RUN, 1 FLASH, 2 DONE
  logic        m_ior = 1'b0, m_fe = 1'b0, m_hold = 1'b0, m_inrdy = 1'b0;
  logic [15:0] m_pin = 16'h0000;

  // observation logs
  logic [15:0] fe_log[$];
  logic [15:0] rd_log[$];
  logic [15:0] host_rx[$];
  int          pop_cyc[$];
  logic        prev_ior = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic lb_now();
`ifdef IO_BRIDGE_LOOPBACK_EN
    return loopback && (mode == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    logic acc, hpop, nx_ior, nx_fe, wr_out;
    logic [15:0] nx_pin;
    int nx_mode;
    if (!rst) begin
      in_q.delete(); out_q.delete();
      mode = 0; m_ior = 1'b0; m_fe = 1'b0; m_hold = 1'b0; m_inrdy = 1'b0; m_pin = 16'h0000;
      return;
    end
    acc     = bus.HostInValid && m_inrdy && !lb_now();
    hpop    = (out_q.size() > 0) && bus.HostOutReady;
    nx_ior  = 1'b0; nx_fe = 1'b0; nx_pin = m_pin; nx_mode = mode; wr_out = 1'b0;
    if (hpop) begin
      host_rx.push_back(bus.HostOutData);
      pop_cyc.push_back(cyc);
    end
    case (mode)
      0: begin
        if (bus.HostFlash && !m_ior) begin
          nx_mode = 1;
          in_q.delete();
        end else begin
          if (bus.IOWaiting && !m_ior) begin
            if (!bus.IOWrite) begin
              if (in_q.size() > 0) begin nx_pin = in_q.pop_front(); nx_ior = 1'b1; end
            end else if (lb_now()) begin
              if (in_q.size() < D) begin in_q.push_back(bus.ParallelOut); nx_ior = 1'b1; end
            end else if (out_q.size() < D || hpop) begin
              wr_out = 1'b1; nx_ior = 1'b1;
            end
          end
          if (acc) in_q.push_back(bus.HostInData);
        end
      end
      1: if (acc) begin
        nx_fe = 1'b1; nx_pin = bus.HostInData;
        if (bus.HostLast) nx_mode = 2;
      end
      default: nx_mode = 0;
    endcase
    if (hpop) void'(out_q.pop_front());
    if (wr_out) out_q.push_back(bus.ParallelOut);
    mode = nx_mode; m_ior = nx_ior; m_fe = nx_fe; m_pin = nx_pin;
    m_hold  = (nx_mode != 0);
    m_inrdy = (nx_mode == 1) || ((nx_mode == 0) && (in_q.size() < D));
  endtask

  // one clock: advance the model on current inputs, then compare every output after the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk1("IOReady", bus.IOReady, m_ior);
    chk16("ParallelIn", bus.ParallelIn, m_pin);
    chk1("FlashEnable", bus.FlashEnable, m_fe);
    chk1("CoreHold", bus.CoreHold, m_hold);
    chk1("HostInReady", bus.HostInReady, m_inrdy && !lb_now());
    chk1("HostOutValid", bus.HostOutValid, out_q.size() > 0);
    if (out_q.size() > 0) chk16("HostOutData", bus.HostOutData, out_q[0]);
    if (bus.IOReady) begin
      chk1("no_b2b_ioready", prev_ior, 1'b0);
      rd_log.push_back(bus.ParallelIn);
    end
    if (bus.FlashEnable) fe_log.push_back(bus.ParallelIn);
    prev_ior = bus.IOReady;
  endtask

  task automatic wait_pulse(input int lim, output bit got);
    got = 1'b0;
    for (int k = 0; k < lim && !got; k++) begin
      tick();
      if (bus.IOReady) got = 1'b1;
    end
  endtask

  initial begin
    bit got;
    int acc_int, p5, idx;
    bit saw_low, acc;
    logic [15:0] wl[8];

    rst = 1'b0;
`ifdef IO_BRIDGE_LOOPBACK_EN
    loopback = 1'b0;
`endif
    bus.HostInData = 16'h0000; bus.HostInValid = 1'b0; bus.HostOutReady = 1'b0;
    bus.HostFlash = 1'b0; bus.HostLast = 1'b0; bus.IOWaiting = 1'b0; bus.IOWrite = 1'b0;
    bus.ParallelOut = 16'h0000;

    // reset values
    repeat (3) tick();
    chk1("rst_IOReady", bus.IOReady, 1'b0);
    chk1("rst_FlashEnable", bus.FlashEnable, 1'b0);
    chk1("rst_CoreHold", bus.CoreHold, 1'b0);
    chk16("rst_ParallelIn", bus.ParallelIn, 16'h0000);
    chk1("rst_HostInReady", bus.HostInReady, 1'b0);
    chk1("rst_HostOutValid", bus.HostOutValid, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    chk1("run_HostInReady", bus.HostInReady, 1'b1);

    // flash three words
    fe_log.delete();
    bus.HostFlash = 1'b1; tick();
    bus.HostFlash = 1'b0;
    chk1("flash_hold", bus.CoreHold, 1'b1);
    bus.HostInValid = 1'b1; bus.HostInData = 16'h1234; tick();
    bus.HostInData = 16'h5678; tick();
    bus.HostInData = 16'h9ABC; bus.HostLast = 1'b1; tick();
    bus.HostInValid = 1'b0; bus.HostLast = 1'b0;
    chk1("done_hold", bus.CoreHold, 1'b1);
    chk1("done_last_fe", bus.FlashEnable, 1'b1);
    tick();
    chk1("after_done_hold", bus.CoreHold, 1'b0);
    chk1("after_done_fe", bus.FlashEnable, 1'b0);
    tick();
    chkn("flash_count", fe_log.size(), 3);
    if (fe_log.size() == 3) begin
      chk16("flash_w0", fe_log[0], 16'h1234);
      chk16("flash_w1", fe_log[1], 16'h5678);
      chk16("flash_w2", fe_log[2], 16'h9ABC);
    end

    // reset in the middle of a load
    bus.HostFlash = 1'b1; tick();
    bus.HostFlash = 1'b0;
    bus.HostInValid = 1'b1; bus.HostInData = 16'h1111; tick();
    bus.HostInValid = 1'b0;
    rst = 1'b0; tick(); tick();
    chk1("midrst_fe", bus.FlashEnable, 1'b0);
    chk1("midrst_hold", bus.CoreHold, 1'b0);
    chk16("midrst_pin", bus.ParallelIn, 16'h0000);
    chk1("midrst_inrdy", bus.HostInReady, 1'b0);
    rst = 1'b1; tick();
    chk1("midrst_rel_fe", bus.FlashEnable, 1'b0);
    chk1("midrst_rel_hold", bus.CoreHold, 1'b0);
    chk1("midrst_rel_inrdy", bus.HostInReady, 1'b1);

    // read stalls on empty FIFO, then completes two cycles after host accept
    rd_log.delete();
    bus.IOWaiting = 1'b1; bus.IOWrite = 1'b0;
    repeat (5) tick();
    chkn("rd_empty_no_pulse", rd_log.size(), 0);
    bus.HostInValid = 1'b1; bus.HostInData = 16'h00FF;
    acc_int = cyc;
    tick();
    bus.HostInValid = 1'b0;
    wait_pulse(5, got);
    bus.IOWaiting = 1'b0;
    chk1("rd_pulse_seen", got, 1'b1);
    chkn("rd_latency", cyc, acc_int + 2);
    chk16("rd_data", bus.ParallelIn, 16'h00FF);
    tick();

    // four writes fill the output FIFO, the fifth stalls until the host pops
    host_rx.delete(); pop_cyc.delete();
    bus.HostOutReady = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      bus.IOWaiting = 1'b1; bus.IOWrite = 1'b1; bus.ParallelOut = 16'(v);
      wait_pulse(6, got);
      if (v < 5) begin
        chk1("wr_ack", got, 1'b1);
        bus.IOWaiting = 1'b0;
        tick();
      end else begin
        chk1("wr5_stalled", got, 1'b0);
      end
    end
    bus.HostOutReady = 1'b1;
    p5 = -1;
    for (int k = 0; k < 20 && (host_rx.size() < 5 || p5 < 0); k++) begin
      tick();
      if (bus.IOReady && p5 < 0) begin p5 = cyc; bus.IOWaiting = 1'b0; end
    end
    bus.IOWaiting = 1'b0;
    chkn("wr_rx_count", host_rx.size(), 5);
    for (int i = 0; i < 5 && i < host_rx.size(); i++) chk16("wr_rx_order", host_rx[i], 16'(i + 1));
    if (pop_cyc.size() > 0) chkn("wr5_after_first_pop", p5, pop_cyc[0] + 1);
    else chkn("wr5_first_pop_seen", 0, 1);
    tick();

    // host fills the input FIFO while the core reads continuously
    for (int i = 0; i < 8; i++) wl[i] = 16'hA000 + 16'(i * 17);
    rd_log.delete();
    bus.IOWaiting = 1'b1; bus.IOWrite = 1'b0;
    idx = 0; saw_low = 1'b0;
    for (int k = 0; k < 60 && rd_log.size() < 8; k++) begin
      if (idx < 8) begin bus.HostInValid = 1'b1; bus.HostInData = wl[idx]; end
      else bus.HostInValid = 1'b0;
      acc = bus.HostInValid && bus.HostInReady;
      if (bus.HostInValid && !bus.HostInReady) saw_low = 1'b1;
      tick();
      if (acc) idx++;
    end
    bus.IOWaiting = 1'b0; bus.HostInValid = 1'b0;
    chk1("fill_ready_dropped", saw_low, 1'b1);
    chkn("fill_count", rd_log.size(), 8);
    for (int i = 0; i < 8 && i < rd_log.size(); i++) chk16("fill_order", rd_log[i], wl[i]);
    tick();

`ifdef IO_BRIDGE_LOOPBACK_EN
    // loopback: a core write comes back on the next core read
    loopback = 1'b1;
    bus.IOWaiting = 1'b1; bus.IOWrite = 1'b1; bus.ParallelOut = 16'hBEEF;
    wait_pulse(5, got);
    chk1("lb_wr_ack", got, 1'b1);
    bus.IOWaiting = 1'b0; tick();
    bus.IOWaiting = 1'b1; bus.IOWrite = 1'b0;
    wait_pulse(5, got);
    bus.IOWaiting = 1'b0;
    chk1("lb_rd_ack", got, 1'b1);
    chk16("lb_rd_data", bus.ParallelIn, 16'hBEEF);
    chk1("lb_outvalid", bus.HostOutValid, 1'b0);
    loopback = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
